rq_pkt_store: RTL and testbench
===============================

# rq_pkt_store

Parametrised store-and-forward packet buffer for the Requester-request (RQ) AXI-Stream path, sitting in the PCIe clock domain between the clock-crossing FIFO and the output register slice.
- Releases a packet downstream only once its last beat is stored, so the PCIe core never sees a stalled mid-packet stream.
- Generalises the fixed 256-bit/16-deep packet store: width, depth and carried tuser bits are parameters.
- Adds a cut-through fallback that prevents deadlock when a packet is longer than the buffer.

## Interface
Parameters:
- DATA_W, 256, tdata width.
- KEEP_W, DATA_W/32, tkeep width (dword granularity).
- USER_W, 8, low tuser bits stored (first_be/last_be). Upper tuser bits are driven 0.
- ADDR_W, 4, log2 of buffer depth in beats (depth = 2^ADDR_W).

Ports:
- pcie_clk, in, 1, sole clock.
- pcie_rst, in, 1, reset, synchronous, active-high.
- s_axis_rq_tvalid / tlast, in, 1 each, input beat and end-of-packet.
- s_axis_rq_tdata / tkeep / tuser, in, DATA_W / KEEP_W / USER_W.
- s_axis_rq_tready, out, 1, = !full.
- m_axis_rq_tvalid / tlast, out, 1 each.
- m_axis_rq_tdata / tkeep, out, DATA_W / KEEP_W.
- m_axis_rq_tuser, out, 60, {zeros, stored USER_W bits}.
- m_axis_rq_tready, in, 1.
- occupancy, out, ADDR_W+1, beats stored.
- pkt_cnt, out, ADDR_W+1, complete packets stored.
- cut_through, out, 1, fallback mode active.

## Operation
- Write: a beat is stored when s_tvalid & s_tready. Storage word is {tlast, tkeep, tuser, tdata}.
- Read: the buffer is first-word-fall-through. m_tvalid = !empty & (pkt_cnt != 0 | cut_through). Read fires on m_tvalid & m_tready.
- When m_tvalid=0, m_tdata, m_tkeep, m_tlast and m_tuser are driven 0.
- pkt_cnt:
  - +1 on a written tlast beat.
  - −1 on a read tlast beat.
  - Unchanged when both happen in the same cycle.
  - Never exceeds depth.
- occupancy: +1 on a write, −1 on a read, unchanged when both happen. full = (occupancy == 2^ADDR_W). empty = (occupancy == 0).
- Cut-through state machine:
  - STORE (reset state): goes to CUT when full & pkt_cnt==0. At that point the buffer holds a partial packet that can never complete.
  - CUT: beats drain as they arrive. Returns to STORE on the cycle a tlast beat is read **and** that beat was written while in CUT. A tlast read that completes a pre-counted packet does not exit CUT.
  - cut_through = 1 in CUT.
- In CUT, the counted-packet logic still updates pkt_cnt for the oversize packet's tlast (the +1 on write and −1 on read both apply), so the count stays consistent.
- Pointers wrap modulo 2^ADDR_W. The full/empty distinction comes from occupancy, not from pointer equality.
- Reset mid-packet: all state clears and any partial packet is discarded. Upstream is expected to be reset in the same domain.

## Timing
- Reset values:
  - s_tready=1.
  - m_tvalid=0, with all m_* data outputs 0.
  - occupancy=0, pkt_cnt=0, cut_through=0. State = STORE.
- Store-to-release latency: a tlast beat accepted at edge N drives m_tvalid=1 in the cycle following edge N. A single-beat packet therefore appears 1 cycle after acceptance.
- Throughput: 1 beat/cycle in and out simultaneously.
- s_tready depends only on registered occupancy. There is no combinational path from m_tready to s_tready.
- CUT entry: full with pkt_cnt==0 observed after edge N gives cut_through=1 and m_tvalid=1 in the same cycle (combinational from registered state).

## Configuration
- RQ_PKT_STORE_STAT_EN defined: adds three outputs, each cleared by pcie_rst.
  - stat_pkt_in, 32 bits, wrapping: count of tlast beats written.
  - stat_pkt_out, 32 bits, wrapping: count of tlast beats read.
  - stat_cut_cnt, 16 bits, saturating at 0xFFFF: count of CUT entries.
- Not defined: these ports and their registers are absent. All other behaviour is identical.

## Structure
- Shared package pcieifc_pkg holds:
  - RQ_TUSER_W = 60.
  - Storage-word field offsets: TLAST_BIT, KEEP_LSB, USER_LSB, DATA_LSB, as functions of the parameters.
  - State encoding ST_STORE / ST_CUT.
- Sub-module rq_pkt_store_mem: single-clock, synchronous active-high reset FWFT RAM with pointers. Ports: wen, din, ren, dout, occupancy.
- The parent holds pkt_cnt, the state machine and output gating.

## Test plan
- 3-beat packet, m_tready=1: m_tvalid stays 0 until the tlast beat is accepted, then 3 consecutive beats out with tlast on the 3rd. pkt_cnt goes 0→1→0.
- ADDR_W=4, 16 single-beat packets with m_tready=0: s_tready drops after 16 beats, pkt_cnt=16, occupancy=16. Raising m_tready drains all 16 in order with data intact.
- Simultaneous tlast in and tlast out with pkt_cnt=2: pkt_cnt stays 2 and occupancy is unchanged.
- 20-beat packet into a 16-deep buffer: after 16 beats cut_through=1 and the beats stream out. The 20th beat leaves with tlast, then cut_through=0 and pkt_cnt=0.
- pcie_rst asserted for 1 cycle mid-packet, with 2 beats stored: the next cycle shows occupancy=0, m_tvalid=0, s_tready=1, and a fresh packet passes normally.
- With RQ_PKT_STORE_STAT_EN, after 5 packets plus 1 oversize packet: stat_pkt_in=6, stat_pkt_out=6, stat_cut_cnt=1.

Source files
------------

// File: rtl/pcieifc_pkg.sv
// pcieifc_pkg: shared RQ constants, packet-store word layout and state encoding.
package pcieifc_pkg;
    localparam int RQ_TUSER_W = 60;
    localparam int DATA_LSB = 0;
    function automatic int USER_LSB(int data_w);
        return data_w;
    endfunction
    function automatic int KEEP_LSB(int data_w, int user_w);
        return data_w + user_w;
    endfunction
    function automatic int TLAST_BIT(int data_w, int user_w, int keep_w);
        return data_w + user_w + keep_w;
    endfunction
    typedef enum logic {ST_STORE, ST_CUT} rq_state_e;
endpackage

// File: rtl/rq_pkt_store_if.sv
// rq_pkt_store_if: AXI-Stream RQ beat bundle with master/slave views.
interface rq_pkt_store_if #(
    parameter int DATA_W = 256,
    parameter int KEEP_W = DATA_W / 32,
    parameter int USER_W = 8
);
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic [USER_W-1:0] tuser;
    modport master(output tvalid, tlast, tdata, tkeep, tuser, input tready);
    modport slave(input tvalid, tlast, tdata, tkeep, tuser, output tready);
endinterface

// File: rtl/rq_pkt_store_mem.sv
// rq_pkt_store_mem: first-word-fall-through RAM; full/empty come from occupancy, not pointer equality.
module rq_pkt_store_mem #(
    parameter int W      = 8,
    parameter int ADDR_W = 4
) (
    input  logic              pcie_clk,
    input  logic              pcie_rst,
    input  logic              wen,
    input  logic [W-1:0]      din,
    input  logic              ren,
    output logic [W-1:0]      dout,
    output logic [ADDR_W:0]   occupancy
);
    logic [W-1:0]      mem [2**ADDR_W];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    always_ff @(posedge pcie_clk)
        if (wen) mem[wr_ptr] <= din;

    always_ff @(posedge pcie_clk)
        if (pcie_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            wr_ptr    <= wr_ptr + ADDR_W'(wen);
            rd_ptr    <= rd_ptr + ADDR_W'(ren);
            occupancy <= occupancy + (ADDR_W+1)'(wen) - (ADDR_W+1)'(ren);
        end

    assign dout = mem[rd_ptr];
endmodule

// File: rtl/rq_pkt_store.sv
// rq_pkt_store: store-and-forward RQ packet buffer with cut-through fallback for oversize packets.
// Define RQ_PKT_STORE_STAT_EN to add the stat_pkt_in/stat_pkt_out/stat_cut_cnt counters.
module rq_pkt_store
    import pcieifc_pkg::*;
#(
    parameter int DATA_W = 256,
    parameter int KEEP_W = DATA_W / 32,
    parameter int USER_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic            pcie_clk,
    input  logic            pcie_rst,
    rq_pkt_store_if.slave   s_axis_rq,
    rq_pkt_store_if.master  m_axis_rq,
    output logic [ADDR_W:0] occupancy,
    output logic [ADDR_W:0] pkt_cnt,
    output logic            cut_through
`ifdef RQ_PKT_STORE_STAT_EN
    ,
    output logic [31:0]     stat_pkt_in,
    output logic [31:0]     stat_pkt_out,
    output logic [15:0]     stat_cut_cnt
`endif
);
    localparam int UL = USER_LSB(DATA_W);
    localparam int KL = KEEP_LSB(DATA_W, USER_W);
    localparam int TB = TLAST_BIT(DATA_W, USER_W, KEEP_W);
    localparam int W  = TB + 2;

    logic [W-1:0] din, dout;
    logic         wen, ren, full, empty, rd_last, rd_tag;
    rq_state_e    state, state_n;

    // Top bit tags beats written during CUT so only the oversize packet's tlast ends it.
    assign din     = {cut_through, s_axis_rq.tlast, s_axis_rq.tkeep, s_axis_rq.tuser, s_axis_rq.tdata};
    assign full    = occupancy[ADDR_W];
    assign empty   = occupancy == '0;
    assign rd_last = dout[TB];
    assign rd_tag  = dout[TB+1];
    assign wen     = s_axis_rq.tvalid && !full;
    assign ren     = m_axis_rq.tvalid && m_axis_rq.tready;

    rq_pkt_store_mem #(.W(W), .ADDR_W(ADDR_W)) u_mem (
        .pcie_clk  (pcie_clk),
        .pcie_rst  (pcie_rst),
        .wen       (wen),
        .din       (din),
        .ren       (ren),
        .dout      (dout),
        .occupancy (occupancy)
    );

    assign cut_through        = state == ST_CUT || (full && pkt_cnt == '0);
    assign s_axis_rq.tready   = !full;
    assign m_axis_rq.tvalid   = !empty && (pkt_cnt != '0 || cut_through);
    assign m_axis_rq.tdata    = m_axis_rq.tvalid ? dout[DATA_LSB +: DATA_W] : '0;
    assign m_axis_rq.tkeep    = m_axis_rq.tvalid ? dout[KL +: KEEP_W] : '0;
    assign m_axis_rq.tuser    = m_axis_rq.tvalid ? RQ_TUSER_W'(dout[UL +: USER_W]) : '0;
    assign m_axis_rq.tlast    = m_axis_rq.tvalid && rd_last;

    always_ff @(posedge pcie_clk)
        state <= pcie_rst ? ST_STORE : state_n;

    always_comb begin
        state_n = state;
        state_n = cut_through && !(ren && rd_last && rd_tag) ? ST_CUT : ST_STORE;
    end

    always_ff @(posedge pcie_clk)
        if (pcie_rst) pkt_cnt <= '0;
        else pkt_cnt <= pkt_cnt + (ADDR_W+1)'(wen && s_axis_rq.tlast) - (ADDR_W+1)'(ren && rd_last);

`ifdef RQ_PKT_STORE_STAT_EN
    always_ff @(posedge pcie_clk)
        if (pcie_rst) begin
            stat_pkt_in  <= '0;
            stat_pkt_out <= '0;
            stat_cut_cnt <= '0;
        end else begin
            stat_pkt_in  <= stat_pkt_in + 32'(wen && s_axis_rq.tlast);
            stat_pkt_out <= stat_pkt_out + 32'(ren && rd_last);
            stat_cut_cnt <= stat_cut_cnt + 16'(state == ST_STORE && cut_through && stat_cut_cnt != 16'hFFFF);
        end
`endif
endmodule

// File: tb/tb_rq_pkt_store.sv
// tb_rq_pkt_store: table vectors, directed corner sequences and randomized traffic against a queue model.
module tb_rq_pkt_store;
    import pcieifc_pkg::*;

    localparam int DATA_W = 256;
    localparam int KEEP_W = 8;
    localparam int USER_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic [USER_W-1:0] user;
        bit                last;
        bit                in_cut;
    } beat_t;

    typedef struct {
        bit v, l, r;
        int occ, pkt;
        bit mv, ml, cut;
    } vec_t;

    logic            pcie_clk = 0;
    logic            pcie_rst = 1;
    logic [ADDR_W:0] occupancy, pkt_cnt;
    logic            cut_through;
`ifdef RQ_PKT_STORE_STAT_EN
    logic [31:0]     stat_pkt_in, stat_pkt_out;
    logic [15:0]     stat_cut_cnt;
`endif

    rq_pkt_store_if #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .USER_W(USER_W)) s_if ();
    rq_pkt_store_if #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .USER_W(RQ_TUSER_W)) m_if ();

    rq_pkt_store #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .USER_W(USER_W), .ADDR_W(ADDR_W)) dut (
        .pcie_clk    (pcie_clk),
        .pcie_rst    (pcie_rst),
        .s_axis_rq   (s_if),
        .m_axis_rq   (m_if),
        .occupancy   (occupancy),
        .pkt_cnt     (pkt_cnt),
        .cut_through (cut_through)
`ifdef RQ_PKT_STORE_STAT_EN
        ,
        .stat_pkt_in  (stat_pkt_in),
        .stat_pkt_out (stat_pkt_out),
        .stat_cut_cnt (stat_cut_cnt)
`endif
    );

    always #5 pcie_clk = ~pcie_clk;

    beat_t q[$];
    beat_t cur;
    bit    cut_q, cut_e, acc, fire;
    int    sin, sout, scut;
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string n, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    function automatic int npk();
        int n = 0;
        foreach (q[i]) n += int'(q[i].last);
        return n;
    endfunction

    // Expected outputs follow from the stored beats alone: count of complete packets and the CUT rule.
    task automatic check_model();
        int n = npk();
        bit ce = cut_q || (q.size() == DEPTH && n == 0);
        bit mv = q.size() > 0 && (n > 0 || ce);
        chk("s_tready", s_if.tready, q.size() < DEPTH);
        chk("m_tvalid", m_if.tvalid, mv);
        chk("m_tlast", m_if.tlast, mv ? q[0].last : 1'b0);
        chk("m_tdata", m_if.tdata, mv ? q[0].data : '0);
        chk("m_tkeep", m_if.tkeep, mv ? q[0].keep : '0);
        chk("m_tuser", m_if.tuser, mv ? q[0].user : '0);
        chk("occupancy", occupancy, q.size());
        chk("pkt_cnt", pkt_cnt, n);
        chk("cut_through", cut_through, ce);
        acc   = s_if.tvalid && q.size() < DEPTH;
        fire  = mv && m_if.tready;
        cut_e = ce;
    endtask

    task automatic step(input bit v, input bit l, input bit r);
        beat_t f;
        @(negedge pcie_clk);
        cur.data = {8{$urandom}};
        cur.keep = KEEP_W'($urandom);
        cur.user = USER_W'($urandom);
        cur.last = l;
        s_if.tvalid = v;
        s_if.tlast  = l;
        s_if.tdata  = cur.data;
        s_if.tkeep  = cur.keep;
        s_if.tuser  = cur.user;
        m_if.tready = r;
        #1 check_model();
        @(posedge pcie_clk);
        if (fire) begin
            f = q.pop_front();
            sout += int'(f.last);
        end
        scut += int'(cut_e && !cut_q);
        cut_q = cut_e && !(fire && f.last && f.in_cut);
        if (acc) begin
            cur.in_cut = cut_e;
            q.push_back(cur);
            sin += int'(cur.last);
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge pcie_clk);
        pcie_rst    = 1;
        s_if.tvalid = 0;
        m_if.tready = 0;
        @(posedge pcie_clk);
        #1 pcie_rst = 0;
        q.delete();
        cut_q = 0;
        sin = 0;
        sout = 0;
        scut = 0;
    endtask

    task automatic drain();
        for (int c = 0; c < 100 && q.size() > 0; c++) step(0, 0, 1);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d beats left expected 0", q.size());
        end
    endtask

    vec_t vt[11];

    initial begin
        s_if.tvalid = 0;
        s_if.tlast  = 0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tuser  = '0;
        m_if.tready = 0;
        do_reset();
        chk("rst_s_tready", s_if.tready, 1);
        chk("rst_m_tvalid", m_if.tvalid, 0);
        chk("rst_m_tdata", m_if.tdata, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_cut", cut_through, 0);

        // 3-beat packet streamed through, then simultaneous tlast in/out at pkt_cnt=2
        vt[0]  = '{1, 0, 1, 1, 0, 0, 0, 0};
        vt[1]  = '{1, 0, 1, 2, 0, 0, 0, 0};
        vt[2]  = '{1, 1, 1, 3, 1, 1, 0, 0};
        vt[3]  = '{0, 0, 1, 2, 1, 1, 0, 0};
        vt[4]  = '{0, 0, 1, 1, 1, 1, 1, 0};
        vt[5]  = '{0, 0, 1, 0, 0, 0, 0, 0};
        vt[6]  = '{1, 1, 0, 1, 1, 1, 1, 0};
        vt[7]  = '{1, 1, 0, 2, 2, 1, 1, 0};
        vt[8]  = '{1, 1, 1, 2, 2, 1, 1, 0};
        vt[9]  = '{0, 0, 1, 1, 1, 1, 1, 0};
        vt[10] = '{0, 0, 1, 0, 0, 0, 0, 0};
        foreach (vt[i]) begin
            step(vt[i].v, vt[i].l, vt[i].r);
            chk($sformatf("vec%0d_occ", i), occupancy, vt[i].occ);
            chk($sformatf("vec%0d_pkt", i), pkt_cnt, vt[i].pkt);
            chk($sformatf("vec%0d_mvalid", i), m_if.tvalid, vt[i].mv);
            chk($sformatf("vec%0d_mlast", i), m_if.tlast, vt[i].ml);
            chk($sformatf("vec%0d_cut", i), cut_through, vt[i].cut);
        end

        // 16 single-beat packets held back, then drained in order
        for (int i = 0; i < 16; i++) step(1, 1, 0);
        chk("fill_s_tready", s_if.tready, 0);
        chk("fill_pkt_cnt", pkt_cnt, 16);
        chk("fill_occupancy", occupancy, 16);
        chk("fill_cut", cut_through, 0);
        drain();
        chk("fill_drained_occ", occupancy, 0);

        // 5 packets then one 20-beat packet forcing cut-through
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 1, 1);
        drain();
        begin
            int sent = 0;
            for (int c = 0; c < 200 && sent < 20; c++) begin
                step(1, sent == 19, 1);
                if (acc) begin
                    sent++;
                    if (sent == 16) begin
                        chk("cut_entry", cut_through, 1);
                        chk("cut_entry_mvalid", m_if.tvalid, 1);
                    end
                end
            end
            chk("oversize_sent", sent, 20);
        end
        drain();
        chk("cut_exit", cut_through, 0);
        chk("cut_exit_pkt", pkt_cnt, 0);
`ifdef RQ_PKT_STORE_STAT_EN
        chk("stat_pkt_in", stat_pkt_in, 6);
        chk("stat_pkt_out", stat_pkt_out, 6);
        chk("stat_cut_cnt", stat_cut_cnt, 1);
`endif

        // reset with a partial packet stored
        step(1, 0, 0);
        step(1, 0, 0);
        chk("mid_occ", occupancy, 2);
        do_reset();
        chk("mid_rst_occ", occupancy, 0);
        chk("mid_rst_mvalid", m_if.tvalid, 0);
        chk("mid_rst_s_tready", s_if.tready, 1);
        chk("mid_rst_pkt", pkt_cnt, 0);
        step(1, 0, 1);
        step(1, 1, 1);
        drain();

        // randomized traffic, alternating short/long packets and light/heavy backpressure
        for (int b = 0; b < 10; b++) begin
            int lp = (b % 2 == 0) ? 5 : 30;
            for (int c = 0; c < 200; c++)
                step($urandom % 4 != 0, $urandom % lp == 0,
                     (b % 3 == 0) ? ($urandom % 8 == 0) : ($urandom % 4 != 0));
        end
        step(1, 1, 1);
        drain();
`ifdef RQ_PKT_STORE_STAT_EN
        chk("rand_stat_in", stat_pkt_in, sin);
        chk("rand_stat_out", stat_pkt_out, sout);
        chk("rand_stat_cut", stat_cut_cnt, scut);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
